// File: rtl/irq_controller_pkg.sv
// Shared definitions for the external-interrupt controller: the register
// window offsets, the FSM state encoding, the interrupt ID width, and a
// byte-enable expansion helper.
package irq_controller_pkg;

    localparam int ID_W = 5;

    // Word offsets within the register window (byte address bits [4:2])
    localparam logic [2:0] OFF_PENDING  = 3'd0;
    localparam logic [2:0] OFF_ENABLE   = 3'd1;
    localparam logic [2:0] OFF_EDGE_SEL = 3'd2;
    localparam logic [2:0] OFF_CLAIM    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // Expand the 4 byte enables into a 32-bit bit mask
    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: the lowest set index wins and is reported as
// index+1. An all-zero input reports ID 0, meaning "none".
module irq_priority_encoder
    import irq_controller_pkg::*;
#(
    parameter int N_SOURCES = 8
) (
    input  logic [N_SOURCES-1:0] eligible_i,
    output logic [ID_W-1:0]      id_o
);

    // Scan from the top index down so that the lowest set index is the last to write
    always_comb begin
        id_o = '0;
        for (int i = N_SOURCES - 1; i >= 0; i--) begin
            if (eligible_i[i]) id_o = ID_W'(i + 1);
        end
    end

endmodule

// File: rtl/irq_controller.sv
// External-interrupt controller. Latches up to N_SOURCES peripheral lines,
// each in edge or level mode, and masks them with ENABLE. It raises
// E_IRQ_OUT toward the core and runs a claim/complete handshake with
// software through a small register window.
//
// Optional build macro IRQ_SYNC_EN: adds a 2-flop synchronizer on every
// IRQ_SRC line, which raises the input-to-E_IRQ_OUT latency from 2 to 4
// cycles.
//
// state   | meaning
// IDLE    | nothing eligible, or an eligible source not yet seen by the FSM
// REQ     | E_IRQ_OUT asserted, waiting for software to claim
// SERVICE | one ID claimed (CLAIMED_ID), no nesting, waiting for complete
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int N_SOURCES = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [N_SOURCES-1:0] IRQ_SRC,
    input  logic [2:0]           ADDR,
    input  logic                 WR_EN,
    input  logic [3:0]           WR_MASK,
    input  logic [31:0]          WR_DATA,
    input  logic                 RD_EN,
    output logic [31:0]          RD_DATA,
    output logic                 E_IRQ_OUT,
    output logic [ID_W-1:0]      CLAIMED_ID
);

    logic [N_SOURCES-1:0] src_s;
    logic [N_SOURCES-1:0] src_prev_q;
    logic [N_SOURCES-1:0] pending_q, pending_d;
    logic [N_SOURCES-1:0] enable_q, enable_d;
    logic [N_SOURCES-1:0] edge_sel_q, edge_sel_d;
    logic [N_SOURCES-1:0] eligible;
    logic [N_SOURCES-1:0] rise;
    logic [N_SOURCES-1:0] clr;
    irq_state_e           state_q, state_d;
    logic [ID_W-1:0]      claimed_id_q, claimed_id_d;
    logic [ID_W-1:0]      best_id;
    logic                 e_irq_q, e_irq_d;
    logic [31:0]          rd_data_q, rd_data_d;
    logic                 rd_claim, wr_claim, claim_take;

    // Merge a byte-masked bus write into an N_SOURCES-wide register
    function automatic logic [N_SOURCES-1:0] apply_wr(input logic [N_SOURCES-1:0] old,
                                                      input logic [31:0] data,
                                                      input logic [3:0] be);
        logic [31:0] m;
        logic [31:0] old32;
        m     = byte_mask(be);
        old32 = 32'(old);
        return N_SOURCES'((old32 & ~m) | (data & m));
    endfunction

`ifdef IRQ_SYNC_EN
    logic [N_SOURCES-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous peripheral lines
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= IRQ_SRC;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = IRQ_SRC;
`endif

    assign rd_claim = RD_EN && (ADDR == OFF_CLAIM);
    assign wr_claim = WR_EN && (ADDR == OFF_CLAIM);
    assign eligible = pending_q & enable_q;
    assign rise     = src_s & ~src_prev_q;

    irq_priority_encoder #(
        .N_SOURCES (N_SOURCES)
    ) u_prio (
        .eligible_i (eligible),
        .id_o       (best_id)
    );

    // Byte-masked writes to the RW configuration registers
    always_comb begin
        enable_d   = enable_q;
        edge_sel_d = edge_sel_q;
        if (WR_EN) begin
            case (ADDR)
                OFF_ENABLE:   enable_d   = apply_wr(enable_q, WR_DATA, WR_MASK);
                OFF_EDGE_SEL: edge_sel_d = apply_wr(edge_sel_q, WR_DATA, WR_MASK);
                default: ;
            endcase
        end
    end

    // Claim/complete FSM: next state, claimed ID, and the registered request
    always_comb begin
        state_d      = state_q;
        claimed_id_d = claimed_id_q;
        claim_take   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_claim && (best_id != '0)) begin
                    state_d      = ST_SERVICE;
                    claimed_id_d = best_id;
                    claim_take   = 1'b1;
                end else if (eligible != '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (rd_claim && (best_id != '0)) begin
                    state_d      = ST_SERVICE;
                    claimed_id_d = best_id;
                    claim_take   = 1'b1;
                end else if (eligible == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                // The ID sits in byte 0, so a complete needs that byte enabled
                if (wr_claim && WR_MASK[0] && (WR_DATA[ID_W-1:0] == claimed_id_q)) begin
                    state_d      = ST_IDLE;
                    claimed_id_d = '0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                claimed_id_d = '0;
            end
        endcase
        e_irq_d = (state_d == ST_REQ);
    end

    // Pending update: a claim clears only an edge bit, and a new edge in the same cycle wins
    always_comb begin
        clr = '0;
        for (int i = 0; i < N_SOURCES; i++) begin
            if (claim_take && (best_id == ID_W'(i + 1))) clr[i] = 1'b1;
        end
        pending_d = (edge_sel_q & ((pending_q & ~clr) | rise)) | (~edge_sel_q & src_s);
    end

    // Register read mux; data always reflects state from before this cycle's write
    always_comb begin
        rd_data_d = rd_data_q;
        if (RD_EN) begin
            case (ADDR)
                OFF_PENDING:  rd_data_d = 32'(pending_q);
                OFF_ENABLE:   rd_data_d = 32'(enable_q);
                OFF_EDGE_SEL: rd_data_d = 32'(edge_sel_q);
                OFF_CLAIM:    rd_data_d = (state_q != ST_SERVICE) ? 32'(best_id) : 32'h0;
                OFF_STATUS:   rd_data_d = {29'b0, 2'(state_q), e_irq_q};
                default:      rd_data_d = 32'h0;
            endcase
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            src_prev_q   <= '0;
            pending_q    <= '0;
            enable_q     <= '0;
            edge_sel_q   <= '0;
            state_q      <= ST_IDLE;
            claimed_id_q <= '0;
            e_irq_q      <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            src_prev_q   <= src_s;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            edge_sel_q   <= edge_sel_d;
            state_q      <= state_d;
            claimed_id_q <= claimed_id_d;
            e_irq_q      <= e_irq_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign RD_DATA    = rd_data_q;
    assign E_IRQ_OUT  = e_irq_q;
    assign CLAIMED_ID = claimed_id_q;

endmodule
